// File: rtl/mac_instruction_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : mac_instruction_dispatcher (with mac_instruction_dispatcher_pkg)
// Brief    : Pops decoded MAC instructions and sequences the unified-buffer
//            read stream plus the latency-delayed result write stream.
// Revision : 1.0
// ============================================================================

package mac_instruction_dispatcher_pkg;
    localparam int ADDR_W = 12;
    localparam int DIM_W  = 8;

    typedef struct packed {
        logic [2:0]        mac_op;
        logic [ADDR_W-1:0] start_addr_rd;
        logic [ADDR_W-1:0] start_addr_wr;
        logic [DIM_W-1:0]  v_dim;
        logic [DIM_W-1:0]  u_dim;
        logic [DIM_W-1:0]  iter_dim;
    } decoded_instr_t;
endpackage

module mac_instruction_dispatcher #(
    parameter int MAC_LATENCY = 4,
    parameter int ADDR_W      = mac_instruction_dispatcher_pkg::ADDR_W,
    parameter int DIM_W       = mac_instruction_dispatcher_pkg::DIM_W
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           iq_empty_i,
    input  mac_instruction_dispatcher_pkg::decoded_instr_t decoded_instr_i,
    output logic                                           iq_read_o,
    input  logic                                           stall_i,
    output logic                                           ub_rd_en_o,
    output logic [ADDR_W-1:0]                              ub_rd_addr_o,
    output logic                                           acc_clear_o,
    output logic [2:0]                                     mac_op_o,
    output logic                                           ub_wr_en_o,
    output logic [ADDR_W-1:0]                              ub_wr_addr_o,
    output logic                                           busy_o,
    output logic                                           instr_done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t                 state;
    logic [DIM_W-1:0]       u_dim;
    logic [DIM_W-1:0]       iter_dim;
    logic [DIM_W-1:0]       u_cnt;
    logic [DIM_W-1:0]       iter_cnt;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [ADDR_W-1:0]      wr_start;
    logic [ADDR_W-1:0]      wr_cnt;
    logic [MAC_LATENCY-1:0] dly;

    logic                   dims_zero;
    logic                   last_u;
    logic                   last_pos;
    logic                   load_go;
    logic                   run_adv;
    logic                   issue;
    logic                   shift_en;
    logic                   dly_in;
    logic                   dly_exit;
    logic [MAC_LATENCY:0]   dly_ext;
    logic [DIM_W-1:0]       u_nxt;
    logic [DIM_W-1:0]       iter_nxt;
    logic [ADDR_W-1:0]      ptr_nxt;

    // Counters always describe the read currently on ub_rd_*; LOAD issues
    // read 0 directly so it appears in the cycle right after LOAD.
    always_comb begin
        dims_zero = (decoded_instr_i.v_dim == '0) || (decoded_instr_i.u_dim == '0) ||
                    (decoded_instr_i.iter_dim == '0);
        last_u    = (u_cnt == u_dim - DIM_ONE);
        last_pos  = last_u && (iter_cnt == iter_dim - DIM_ONE);
        load_go   = (state == LOAD) && !dims_zero;
        run_adv   = (state == RUN) && !stall_i && !last_pos;
        issue     = load_go || run_adv;
        if (load_go) begin
            u_nxt    = '0;
            iter_nxt = '0;
            ptr_nxt  = decoded_instr_i.start_addr_rd;
        end else begin
            u_nxt    = last_u ? '0 : u_cnt + DIM_ONE;
            iter_nxt = last_u ? iter_cnt + DIM_ONE : iter_cnt;
            ptr_nxt  = rd_ptr + ADDR_ONE;
        end
        dly_in   = issue && (load_go ? (decoded_instr_i.iter_dim == DIM_ONE)
                                     : (iter_nxt == iter_dim - DIM_ONE));
        // The line is always empty in LOAD, so it may shift regardless of stall.
        shift_en = (state == LOAD) || !stall_i;
        dly_ext  = {dly, dly_in};
        dly_exit = dly_ext[MAC_LATENCY];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            u_dim        <= '0;
            iter_dim     <= '0;
            u_cnt        <= '0;
            iter_cnt     <= '0;
            rd_ptr       <= '0;
            wr_start     <= '0;
            wr_cnt       <= '0;
            dly          <= '0;
            iq_read_o    <= 1'b0;
            ub_rd_en_o   <= 1'b0;
            ub_rd_addr_o <= '0;
            acc_clear_o  <= 1'b0;
            mac_op_o     <= '0;
            ub_wr_en_o   <= 1'b0;
            ub_wr_addr_o <= '0;
            busy_o       <= 1'b0;
            instr_done_o <= 1'b0;
        end else begin
            iq_read_o    <= 1'b0;
            instr_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!iq_empty_i) begin
                        state  <= SETTLE;
                        busy_o <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (iq_empty_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state     <= LOAD;
                        iq_read_o <= 1'b1;
                    end
                end
                LOAD: begin
                    mac_op_o <= decoded_instr_i.mac_op;
                    u_dim    <= decoded_instr_i.u_dim;
                    iter_dim <= decoded_instr_i.iter_dim;
                    wr_start <= decoded_instr_i.start_addr_wr;
                    wr_cnt   <= '0;
                    state    <= dims_zero ? DRAIN : RUN;
                end
                RUN: begin
                    if (!stall_i && last_pos) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dly == '0) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        instr_done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            ub_rd_en_o  <= issue;
            acc_clear_o <= issue && (iter_nxt == '0);
            if (issue) begin
                ub_rd_addr_o <= ptr_nxt;
                rd_ptr       <= ptr_nxt;
                u_cnt        <= u_nxt;
                iter_cnt     <= iter_nxt;
            end

            if (shift_en) begin
                dly <= dly_ext[MAC_LATENCY-1:0];
            end
            ub_wr_en_o <= shift_en && dly_exit;
            if (shift_en && dly_exit) begin
                ub_wr_addr_o <= wr_start + wr_cnt;
                wr_cnt       <= wr_cnt + ADDR_ONE;
            end
        end
    end

endmodule

`default_nettype wire
